// File: rtl/hack_kbd_pkg.sv
// Shared scancode/Hack-code constants, stack entry type and the scancode translation function.
package hack_kbd_pkg;

    // PS/2 set-2 scancodes with special meaning (extended ones are listed without the E0 prefix)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_HOME   = 8'h6C;
    localparam logic [7:0] SC_END    = 8'h69;
    localparam logic [7:0] SC_PGUP   = 8'h7D;
    localparam logic [7:0] SC_PGDN   = 8'h7A;
    localparam logic [7:0] SC_INS    = 8'h70;
    localparam logic [7:0] SC_DEL    = 8'h71;
    localparam logic [7:0] SC_LGUI   = 8'h1F;
    localparam logic [7:0] SC_RGUI   = 8'h27;

    // nand2tetris special key codes
    localparam logic [7:0] HK_ENTER = 8'd128;
    localparam logic [7:0] HK_BKSP  = 8'd129;
    localparam logic [7:0] HK_LEFT  = 8'd130;
    localparam logic [7:0] HK_UP    = 8'd131;
    localparam logic [7:0] HK_RIGHT = 8'd132;
    localparam logic [7:0] HK_DOWN  = 8'd133;
    localparam logic [7:0] HK_HOME  = 8'd134;
    localparam logic [7:0] HK_END   = 8'd135;
    localparam logic [7:0] HK_PGUP  = 8'd136;
    localparam logic [7:0] HK_PGDN  = 8'd137;
    localparam logic [7:0] HK_INS   = 8'd138;
    localparam logic [7:0] HK_DEL   = 8'd139;
    localparam logic [7:0] HK_ESC   = 8'd140;
    localparam logic [7:0] HK_F1    = 8'd141;
    localparam logic [7:0] HK_F12   = 8'd152;

    typedef struct packed {
        logic       ext;
        logic [7:0] sc;
    } kbd_entry_t;

    // Whether a key is mapped never depends on 'upper', so the tracker can filter presses with upper=0.
    function automatic logic [7:0] kbd_xlate(input logic ext, input logic [7:0] sc,
                                             input logic upper, input logic hack);
        logic [7:0] c;
        logic       hk_only;
        c       = 8'h00;
        hk_only = 1'b0;
        if (!ext) begin
            case (sc)
                8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
                8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
                8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
                8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
                8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
                8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
                8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
                8'h45: c = upper ? 8'h29 : 8'h30;  8'h16: c = upper ? 8'h21 : 8'h31;
                8'h1E: c = upper ? 8'h40 : 8'h32;  8'h26: c = upper ? 8'h23 : 8'h33;
                8'h25: c = upper ? 8'h24 : 8'h34;  8'h2E: c = upper ? 8'h25 : 8'h35;
                8'h36: c = upper ? 8'h5E : 8'h36;  8'h3D: c = upper ? 8'h26 : 8'h37;
                8'h3E: c = upper ? 8'h2A : 8'h38;  8'h46: c = upper ? 8'h28 : 8'h39;
                8'h4E: c = upper ? 8'h5F : 8'h2D;  8'h55: c = upper ? 8'h2B : 8'h3D;
                8'h4A: c = upper ? 8'h3F : 8'h2F;  8'h29: c = 8'h20;
                8'h79: c = 8'h2B;  8'h7C: c = 8'h2A;  8'h7B: c = 8'h2D;
                SC_ENTER: c = hack ? HK_ENTER : 8'd10;
                SC_BKSP:  c = hack ? HK_BKSP  : 8'd8;
                SC_ESC:   begin c = HK_ESC; hk_only = 1'b1; end
                8'h05: begin c = HK_F1;          hk_only = 1'b1; end
                8'h06: begin c = HK_F1 + 8'd1;   hk_only = 1'b1; end
                8'h04: begin c = HK_F1 + 8'd2;   hk_only = 1'b1; end
                8'h0C: begin c = HK_F1 + 8'd3;   hk_only = 1'b1; end
                8'h03: begin c = HK_F1 + 8'd4;   hk_only = 1'b1; end
                8'h0B: begin c = HK_F1 + 8'd5;   hk_only = 1'b1; end
                8'h83: begin c = HK_F1 + 8'd6;   hk_only = 1'b1; end
                8'h0A: begin c = HK_F1 + 8'd7;   hk_only = 1'b1; end
                8'h01: begin c = HK_F1 + 8'd8;   hk_only = 1'b1; end
                8'h09: begin c = HK_F1 + 8'd9;   hk_only = 1'b1; end
                8'h78: begin c = HK_F1 + 8'd10;  hk_only = 1'b1; end
                8'h07: begin c = HK_F12;         hk_only = 1'b1; end
                default: ;
            endcase
            if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        end else begin
            hk_only = 1'b1;
            case (sc)
                SC_LEFT:  c = HK_LEFT;
                SC_UP:    c = HK_UP;
                SC_RIGHT: c = HK_RIGHT;
                SC_DOWN:  c = HK_DOWN;
                SC_HOME:  c = HK_HOME;
                SC_END:   c = HK_END;
                SC_PGUP:  c = HK_PGUP;
                SC_PGDN:  c = HK_PGDN;
                SC_INS:   c = HK_INS;
                SC_DEL:   c = HK_DEL;
                SC_ENTER: begin c = hack ? HK_ENTER : 8'd10; hk_only = 1'b0; end
                8'h4A:    begin c = 8'h2F; hk_only = 1'b0; end
                SC_LGUI:  begin c = hack ? 8'h00 : 8'h11; hk_only = 1'b0; end
                SC_RGUI:  begin c = hack ? 8'h00 : 8'h12; hk_only = 1'b0; end
                default: ;
            endcase
        end
        if (hk_only && !hack) c = 8'h00;
        return c;
    endfunction

endpackage

// File: rtl/hack_kbd_map.sv
// Combinational translation of one {ext, scancode} entry to the 8-bit KBD code.
module hack_kbd_map
    import hack_kbd_pkg::*;
#(
    parameter int HACK_CODES = 1,
    parameter int SHIFT_EN   = 1
) (
    input  logic       ext_i,
    input  logic [7:0] sc_i,
    input  logic       shift_i,
    output logic [7:0] code_o
);
    // Shift only affects the result when shift handling is enabled
    assign code_o = kbd_xlate(ext_i, sc_i, shift_i && (SHIFT_EN != 0), HACK_CODES != 0);
endmodule

// File: rtl/hack_kbd_tracker.sv
// Held-key recency stack feeding the Hack KBD register; index 0 is the most recent key.
module hack_kbd_tracker
    import hack_kbd_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HACK_CODES = 1,
    parameter int SHIFT_EN   = 1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic                       clear,
    output logic [15:0]                kbd_code,
    output logic                       key_valid,
    output logic [$clog2(DEPTH+1)-1:0] held_count,
    output logic                       shift_held,
    output logic                       overflow,
    output logic                       evt_stb
);
    localparam int CW = $clog2(DEPTH+1);

    logic [10:0]   ps2_q;
    logic          tog_q, primed_q;
    kbd_entry_t    stk_q [DEPTH];
    kbd_entry_t    stk_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          shl_q, shl_d, shr_q, shr_d, ovf_q, ovf_d, stb_q;
    logic [7:0]    code_q, code_d, map_code;
    kbd_entry_t    ev, top_d;
    logic          evt, press, is_mod, mapped, hit;
    int            hit_idx;

    // Stage 1: capture the event word; the first sample after reset seeds the toggle tracker so a
    // toggle level left over from before reset is not replayed as a fresh event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_q    <= '0;
            tog_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            ps2_q    <= ps2_key;
            tog_q    <= primed_q ? ps2_q[10] : ps2_key[10];
            primed_q <= 1'b1;
        end
    end

    assign evt    = ps2_q[10] ^ tog_q;
    assign press  = ps2_q[9];
    assign ev     = kbd_entry_t'(ps2_q[8:0]);
    assign is_mod = !ev.ext && (ev.sc == SC_LSHIFT || ev.sc == SC_RSHIFT);
    assign mapped = kbd_xlate(ev.ext, ev.sc, 1'b0, HACK_CODES != 0) != 8'h00;

    // Locate the event key among the occupied stack slots
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && i < int'(cnt_q) && stk_q[i] == ev) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end
    end

    // Next stack/shift state: push-to-top (moving a held key up) or remove-with-compaction
    always_comb begin
        stk_d = stk_q;
        cnt_d = cnt_q;
        shl_d = shl_q;
        shr_d = shr_q;
        ovf_d = ovf_q;
        if (evt && is_mod) begin
            if (ev.sc == SC_LSHIFT) shl_d = press;
            else                    shr_d = press;
        end else if (evt && press && mapped) begin
            // A new key shifts every slot down (the oldest falls off when full); a held key only
            // shifts the slots above its old position.
            for (int i = DEPTH-1; i > 0; i--) begin
                if (!hit || i <= hit_idx) stk_d[i] = stk_q[i-1];
            end
            stk_d[0] = ev;
            if (!hit) begin
                if (int'(cnt_q) == DEPTH) ovf_d = 1'b1;
                else                      cnt_d = cnt_q + CW'(1);
            end
        end else if (evt && !press && hit) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (i >= hit_idx) stk_d[i] = stk_q[i+1];
            end
            stk_d[DEPTH-1] = '0;
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign top_d = stk_d[0];

    hack_kbd_map #(
        .HACK_CODES(HACK_CODES),
        .SHIFT_EN  (SHIFT_EN)
    ) u_map (
        .ext_i  (top_d.ext),
        .sc_i   (top_d.sc),
        .shift_i(shl_d | shr_d),
        .code_o (map_code)
    );

    assign code_d = (cnt_d == '0) ? 8'h00 : map_code;

    // Stage 2: commit stack, shift state and registered outputs; clear beats a same-cycle event
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            cnt_q  <= '0;
            shl_q  <= 1'b0;
            shr_q  <= 1'b0;
            ovf_q  <= 1'b0;
            code_q <= 8'h00;
            stb_q  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            cnt_q  <= '0;
            shl_q  <= 1'b0;
            shr_q  <= 1'b0;
            ovf_q  <= 1'b0;
            code_q <= 8'h00;
            stb_q  <= 1'b0;
        end else begin
            stk_q  <= stk_d;
            cnt_q  <= cnt_d;
            shl_q  <= shl_d;
            shr_q  <= shr_d;
            ovf_q  <= ovf_d;
            code_q <= code_d;
            stb_q  <= (code_d != code_q);
        end
    end

    assign kbd_code   = {8'h00, code_q};
    assign key_valid  = (cnt_q != '0);
    assign held_count = cnt_q;
    assign shift_held = shl_q | shr_q;
    assign overflow   = ovf_q;
    assign evt_stb    = stb_q;

endmodule

// File: tb/tb_hack_kbd_tracker.sv
// Directed scoreboard bench: main DUT (defaults) plus SHIFT_EN=0 and HACK_CODES=0 variants.
module tb_hack_kbd_tracker;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        clear;
    logic        tog;

    logic [15:0] kbd_code, kbd_code_ns, kbd_code_lg;
    logic        key_valid, key_valid_ns, key_valid_lg;
    logic [2:0]  held_count, held_count_ns, held_count_lg;
    logic        shift_held, shift_held_ns, shift_held_lg;
    logic        overflow, overflow_ns, overflow_lg;
    logic        evt_stb, evt_stb_ns, evt_stb_lg;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;
    int stb_base;

    typedef struct {
        logic [7:0] code;
        int         cnt;
        logic       ovf;
        logic       stb;
        logic       shf;
        logic [7:0] code_ns;
        logic [7:0] code_lg;
    } exp_t;

    exp_t sb[$];

    hack_kbd_tracker dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .clear(clear),
        .kbd_code(kbd_code), .key_valid(key_valid), .held_count(held_count),
        .shift_held(shift_held), .overflow(overflow), .evt_stb(evt_stb)
    );

    hack_kbd_tracker #(.SHIFT_EN(0)) dut_ns (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .clear(clear),
        .kbd_code(kbd_code_ns), .key_valid(key_valid_ns), .held_count(held_count_ns),
        .shift_held(shift_held_ns), .overflow(overflow_ns), .evt_stb(evt_stb_ns)
    );

    hack_kbd_tracker #(.HACK_CODES(0)) dut_lg (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .clear(clear),
        .kbd_code(kbd_code_lg), .key_valid(key_valid_lg), .held_count(held_count_lg),
        .shift_held(shift_held_lg), .overflow(overflow_lg), .evt_stb(evt_stb_lg)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (evt_stb === 1'b1) stb_cnt <= stb_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic press, input logic ext, input logic [7:0] sc, input logic clr,
                        input logic [7:0] code, input int cnt, input logic ovf, input logic stb,
                        input logic shf, input logic [7:0] code_ns, input logic [7:0] code_lg);
        exp_t e;
        e.code = code; e.cnt = cnt; e.ovf = ovf; e.stb = stb; e.shf = shf;
        e.code_ns = code_ns; e.code_lg = code_lg;
        @(negedge clk_sys);
        tog     = ~tog;
        ps2_key = {tog, press, ext, sc};
        sb.push_back(e);
        @(posedge clk_sys); #1;
        clear = clr;
        @(posedge clk_sys); #1;
        clear = 1'b0;
        e = sb.pop_front();
        check("kbd_code",   32'(kbd_code),    {24'h0, e.code});
        check("held_count", 32'(held_count),  32'(e.cnt));
        check("key_valid",  32'(key_valid),   32'(e.cnt != 0));
        check("overflow",   32'(overflow),    32'(e.ovf));
        check("evt_stb",    32'(evt_stb),     32'(e.stb));
        check("shift_held", 32'(shift_held),  32'(e.shf));
        check("ns_code",    32'(kbd_code_ns), {24'h0, e.code_ns});
        check("lg_code",    32'(kbd_code_lg), {24'h0, e.code_lg});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_code"},  32'(kbd_code),   32'h0);
        check({tag, "_count"}, 32'(held_count), 32'h0);
        check({tag, "_valid"}, 32'(key_valid),  32'h0);
        check({tag, "_ovf"},   32'(overflow),   32'h0);
        check({tag, "_stb"},   32'(evt_stb),    32'h0);
        check({tag, "_shift"}, 32'(shift_held), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        tog     = 1'b0;
        ps2_key = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_idle("reset");
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        // Two keys, release in reverse order
        stb_base = stb_cnt;
        //   press ext  sc     clr  code   cnt ovf  stb  shf  ns     lg
        send(1'b1, 1'b0, 8'h1C, 1'b0, 8'h61, 1, 1'b0, 1'b1, 1'b0, 8'h61, 8'h61);
        send(1'b1, 1'b0, 8'h32, 1'b0, 8'h62, 2, 1'b0, 1'b1, 1'b0, 8'h62, 8'h62);
        send(1'b0, 1'b0, 8'h32, 1'b0, 8'h61, 1, 1'b0, 1'b1, 1'b0, 8'h61, 8'h61);
        send(1'b0, 1'b0, 8'h1C, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        @(posedge clk_sys); #1;
        check("stb_pulses", 32'(stb_cnt - stb_base), 32'd4);

        // Shift handling
        send(1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        send(1'b1, 1'b0, 8'h1C, 1'b0, 8'h41, 1, 1'b0, 1'b1, 1'b1, 8'h61, 8'h41);
        send(1'b0, 1'b0, 8'h12, 1'b0, 8'h61, 1, 1'b0, 1'b1, 1'b0, 8'h61, 8'h61);
        send(1'b0, 1'b0, 8'h1C, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

        // Extended Left and Enter under both code sets
        send(1'b1, 1'b1, 8'h6B, 1'b0, 8'h82, 1, 1'b0, 1'b1, 1'b0, 8'h82, 8'h00);
        check("lg_left_count", 32'(held_count_lg), 32'h0);
        send(1'b0, 1'b1, 8'h6B, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        send(1'b1, 1'b0, 8'h5A, 1'b0, 8'h80, 1, 1'b0, 1'b1, 1'b0, 8'h80, 8'h0A);
        send(1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

        // Overflow: digits 1..5, key 1 falls off the bottom
        send(1'b1, 1'b0, 8'h16, 1'b0, 8'h31, 1, 1'b0, 1'b1, 1'b0, 8'h31, 8'h31);
        send(1'b1, 1'b0, 8'h1E, 1'b0, 8'h32, 2, 1'b0, 1'b1, 1'b0, 8'h32, 8'h32);
        send(1'b1, 1'b0, 8'h26, 1'b0, 8'h33, 3, 1'b0, 1'b1, 1'b0, 8'h33, 8'h33);
        send(1'b1, 1'b0, 8'h25, 1'b0, 8'h34, 4, 1'b0, 1'b1, 1'b0, 8'h34, 8'h34);
        send(1'b1, 1'b0, 8'h2E, 1'b0, 8'h35, 4, 1'b1, 1'b1, 1'b0, 8'h35, 8'h35);
        send(1'b0, 1'b0, 8'h2E, 1'b0, 8'h34, 3, 1'b1, 1'b1, 1'b0, 8'h34, 8'h34);
        send(1'b0, 1'b0, 8'h25, 1'b0, 8'h33, 2, 1'b1, 1'b1, 1'b0, 8'h33, 8'h33);
        send(1'b0, 1'b0, 8'h26, 1'b0, 8'h32, 1, 1'b1, 1'b1, 1'b0, 8'h32, 8'h32);
        send(1'b0, 1'b0, 8'h1E, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        send(1'b0, 1'b0, 8'h16, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Repeat press moves to top; release of an unheld key is ignored
        send(1'b1, 1'b0, 8'h1C, 1'b0, 8'h61, 1, 1'b1, 1'b1, 1'b0, 8'h61, 8'h61);
        send(1'b1, 1'b0, 8'h32, 1'b0, 8'h62, 2, 1'b1, 1'b1, 1'b0, 8'h62, 8'h62);
        send(1'b1, 1'b0, 8'h1C, 1'b0, 8'h61, 2, 1'b1, 1'b1, 1'b0, 8'h61, 8'h61);
        send(1'b0, 1'b0, 8'h1A, 1'b0, 8'h61, 2, 1'b1, 1'b0, 1'b0, 8'h61, 8'h61);
        send(1'b0, 1'b0, 8'h1C, 1'b0, 8'h62, 1, 1'b1, 1'b1, 1'b0, 8'h62, 8'h62);
        send(1'b0, 1'b0, 8'h32, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Clear in the same cycle as a press event, with three keys held
        send(1'b1, 1'b0, 8'h1C, 1'b0, 8'h61, 1, 1'b1, 1'b1, 1'b0, 8'h61, 8'h61);
        send(1'b1, 1'b0, 8'h32, 1'b0, 8'h62, 2, 1'b1, 1'b1, 1'b0, 8'h62, 8'h62);
        send(1'b1, 1'b0, 8'h21, 1'b0, 8'h63, 3, 1'b1, 1'b1, 1'b0, 8'h63, 8'h63);
        send(1'b1, 1'b0, 8'h23, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk_sys);
        #1;
        check_idle("after_clear");
        send(1'b1, 1'b0, 8'h24, 1'b0, 8'h65, 1, 1'b0, 1'b1, 1'b0, 8'h65, 8'h65);
        send(1'b1, 1'b0, 8'h59, 1'b0, 8'h45, 1, 1'b0, 1'b1, 1'b1, 8'h65, 8'h45);

        // Async reset in the middle of a press event
        @(negedge clk_sys);
        tog     = ~tog;
        ps2_key = {tog, 1'b1, 1'b0, 8'h2B};
        @(posedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_ns", 32'(kbd_code_ns), 32'h0);
        check("async_reset_lg", 32'(kbd_code_lg), 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check_idle("post_reset");
        send(1'b1, 1'b0, 8'h1C, 1'b0, 8'h61, 1, 1'b0, 1'b1, 1'b0, 8'h61, 8'h61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
